eth_rx_fcs_check: RTL
=====================

// Module: eth_rx_fcs_check
// PURPOSE
//  Receive-side FCS checker for the Ethernet MAC. It consumes the RX frame as a stream of
//  16-bit words and runs CRC-32 over every byte, FCS included. At end of frame it compares
//  the final register with the fixed residue and reports a per-frame status word. It sits
//  between the RX deserialiser and the RX buffer write logic, and mirrors the TX FCS generator.
// PARAMETERS
//  LEN_W        16              width of byte-length counter/status
//  MIN_BYTES    64              frames shorter than this (FCS incl.) flag runt
//  MAX_BYTES    1518            frames longer than this (FCS incl.) flag long
//  CRC_INIT     32'hFFFF_FFFF   CRC register value at start of frame
//  CRC_RESIDUE  32'hC704_DD7B   expected register value after FCS bytes
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      in_data word valid this cycle; block is always ready
//  in_sop       in   1      first word of frame (qualified by in_valid)
//  in_eop       in   1      last word of frame (qualified by in_valid)
//  in_odd       in   1      with in_eop: only in_data[15:8] valid
//  in_data      in   16     [15:8] = earlier byte; D[15] is first serial bit
//  stat_valid   out  1      one-cycle pulse: status fields valid
//  stat_crc_ok  out  1      final CRC == CRC_RESIDUE and frame not aborted
//  stat_len     out  LEN_W  frame length in bytes, FCS included, saturating
//  stat_runt    out  1      stat_len < MIN_BYTES
//  stat_long    out  1      stat_len > MAX_BYTES
//  stat_abort   out  1      frame terminated by a new SOP before its EOP
//  crc_cur      out  32     current CRC register (debug/observation)
// BEHAVIOUR
//  - Reset: state IDLE, crc reg = CRC_INIT, len = 0. All stat_* outputs = 0. crc_cur = CRC_INIT.
//  - FSM states:
//    IDLE -> FRAME on in_valid & in_sop & !in_eop.
//    FRAME -> IDLE on in_valid & in_eop.
//    FRAME -> FRAME on in_valid & in_sop (abort + restart).
//  - Word step: crc_nxt = step16(crc, data), len += 2. For an in_eop & in_odd word: crc_nxt =
//    step8(crc, data[7+8:8]), len += 1. in_odd is ignored without in_eop.
//  - SOP word: crc is seeded from CRC_INIT, not the held register, so a stale CRC is never used.
//  - Status is registered. stat_valid rises the cycle after the EOP word is accepted.
//    stat_crc_ok is computed on that word's crc_nxt.
//  - Single-word frame (sop & eop together in IDLE): status pulses next cycle, with runt = 1.
//    State stays IDLE.
//  - SOP while in FRAME: next cycle stat_valid = 1, stat_abort = 1, stat_crc_ok = 0, and stat_len
//    is the length accumulated before the SOP word. The SOP word starts the new frame (len = 2).
//  - in_valid & !in_sop in IDLE: word dropped, no state change.
//  - in_valid = 0 gaps inside a frame hold crc and len unchanged. Gaps have no effect on the result.
//  - len saturates at 2^LEN_W-1; stat_long then = 1.
//  - crc and len reload to CRC_INIT and 0 on the cycle after status issues.
//  - Reset mid-frame: the frame is discarded and no stat_valid is emitted for it.
// STRUCTURE
//  - Package eth_crc_pkg: CRC_INIT, CRC_RESIDUE, MIN/MAX frame constants,
//    typedef enum logic {IDLE, FRAME} fcs_state_t, and typedef struct rx_stat_t
//    (crc_ok, len, runt, long, abort).
//  - Sub-module crc32_d8: combinational 8-bit step for polynomial 0x04C11DB7, same bit
//    convention as the 16-bit step. Instantiated with the team's 16-bit combinational step.
//    Output mux selects by in_eop & in_odd.
// TESTING
//  1. 64-byte frame, correct FCS, 32 back-to-back words -> stat_valid 1 cycle after EOP,
//     crc_ok=1, len=64, runt=0, long=0, abort=0.
//  2. Same frame with data bit 3 of word 5 flipped -> crc_ok=0, len=64.
//  3. 65-byte frame, correct FCS, last word in_odd=1 -> crc_ok=1, len=65. Repeat with
//     in_odd=1 on a non-EOP word -> ignored, len counts 2.
//  4. SOP after 10 words, then a valid 64-byte frame -> pulse1: abort=1, crc_ok=0, len=20;
//     pulse2: crc_ok=1, len=64.
//  5. 60-byte valid frame -> crc_ok=1, runt=1. 1520-byte valid frame -> crc_ok=1, long=1.
//     Single sop&eop word -> runt=1, len=2.
//  6. rst_n low for 2 cycles mid-frame, then a valid 64-byte frame with random in_valid gaps
//     -> no pulse for the aborted frame, then crc_ok=1, len=64.
//     Outputs = 0 during reset and crc_cur = 32'hFFFF_FFFF.

Source files
------------

// File: rtl/eth_crc_pkg.sv
// Shared constants and types for the RX FCS checker.
package eth_crc_pkg;
  localparam int          LEN_W_DEF   = 16;
  localparam int          MIN_FRAME   = 64;
  localparam int          MAX_FRAME   = 1518;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

  typedef enum logic {IDLE, FRAME} fcs_state_t;

  typedef struct packed {
    logic                 crc_ok;
    logic [LEN_W_DEF-1:0] len;
    logic                 runt;
    logic                 long;
    logic                 abort;
  } rx_stat_t;
endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// RX word stream in, per-frame status out.
interface eth_rx_fcs_check_if #(parameter int LEN_W = 16);
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic             in_odd;
  logic [15:0]      in_data;
  logic             stat_valid;
  logic             stat_crc_ok;
  logic [LEN_W-1:0] stat_len;
  logic             stat_runt;
  logic             stat_long;
  logic             stat_abort;
  logic [31:0]      crc_cur;

  modport master (
    output in_valid, in_sop, in_eop, in_odd, in_data,
    input  stat_valid, stat_crc_ok, stat_len, stat_runt, stat_long, stat_abort, crc_cur
  );
  modport slave (
    input  in_valid, in_sop, in_eop, in_odd, in_data,
    output stat_valid, stat_crc_ok, stat_len, stat_runt, stat_long, stat_abort, crc_cur
  );
endinterface

// File: rtl/eth_rx_fcs_check_crc32_d8.sv
// One byte of MSB-first CRC-32 (poly 0x04C11DB7); data[7] enters first.
module crc32_d8
  import eth_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--)
      crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker: CRC-32 over every frame byte incl. FCS, residue compare at EOP.
module eth_rx_fcs_check #(
  parameter int          LEN_W       = eth_crc_pkg::LEN_W_DEF,
  parameter int          MIN_BYTES   = eth_crc_pkg::MIN_FRAME,
  parameter int          MAX_BYTES   = eth_crc_pkg::MAX_FRAME,
  parameter logic [31:0] CRC_INIT    = eth_crc_pkg::CRC_INIT,
  parameter logic [31:0] CRC_RESIDUE = eth_crc_pkg::CRC_RESIDUE
) (
  input logic               clk,
  input logic               rst_n,
  eth_rx_fcs_check_if.slave rx
);
  import eth_crc_pkg::*;

  fcs_state_t       state;
  rx_stat_t         stat_q;
  logic             stat_vld;
  logic [31:0]      crc_q, crc_seed, crc_hi, crc_lo, crc_nxt;
  logic [LEN_W-1:0] len_q, len_base, len_nxt;
  logic [LEN_W:0]   len_sum;
  logic             odd_end, crc_ok;

  // SOP always restarts from the seed so a stale register never leaks into a frame
  assign crc_seed = rx.in_sop ? CRC_INIT : crc_q;
  assign len_base = rx.in_sop ? '0 : len_q;
  assign odd_end  = rx.in_eop & rx.in_odd;

  crc32_d8 u_hi (.crc_in(crc_seed), .data(rx.in_data[15:8]), .crc_out(crc_hi));
  crc32_d8 u_lo (.crc_in(crc_hi),   .data(rx.in_data[7:0]),  .crc_out(crc_lo));

  assign crc_nxt = odd_end ? crc_hi : crc_lo;
  assign crc_ok  = (crc_nxt == CRC_RESIDUE);
  assign len_sum = {1'b0, len_base} + (odd_end ? (LEN_W+1)'(1) : (LEN_W+1)'(2));
  assign len_nxt = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  function automatic rx_stat_t mk_stat(input logic [LEN_W-1:0] l, input logic ok,
                                       input logic ab);
    rx_stat_t s;
    s.crc_ok = ok;
    s.len    = LEN_W_DEF'(l);
    s.runt   = int'(l) < MIN_BYTES;
    s.long   = int'(l) > MAX_BYTES;
    s.abort  = ab;
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_q    <= CRC_INIT;
      len_q    <= '0;
      stat_vld <= 1'b0;
      stat_q   <= '0;
    end else begin
      stat_vld <= 1'b0;
      stat_q   <= '0;
      // reload after status; a new frame in the same cycle overrides below
      if (stat_vld && state == IDLE) begin
        crc_q <= CRC_INIT;
        len_q <= '0;
      end
      case (state)
        IDLE: if (rx.in_valid && rx.in_sop) begin
          crc_q <= crc_nxt;
          len_q <= len_nxt;
          if (rx.in_eop) begin
            stat_vld <= 1'b1;
            stat_q   <= mk_stat(len_nxt, crc_ok, 1'b0);
          end else begin
            state <= FRAME;
          end
        end
        FRAME: if (rx.in_valid) begin
          crc_q <= crc_nxt;
          len_q <= len_nxt;
          if (rx.in_sop) begin
            stat_vld <= 1'b1;
            stat_q   <= mk_stat(len_q, 1'b0, 1'b1);
            if (rx.in_eop) state <= IDLE;
          end else if (rx.in_eop) begin
            stat_vld <= 1'b1;
            stat_q   <= mk_stat(len_nxt, crc_ok, 1'b0);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.stat_valid  = stat_vld;
  assign rx.stat_crc_ok = stat_q.crc_ok;
  assign rx.stat_len    = LEN_W'(stat_q.len);
  assign rx.stat_runt   = stat_q.runt;
  assign rx.stat_long   = stat_q.long;
  assign rx.stat_abort  = stat_q.abort;
  assign rx.crc_cur     = crc_q;
endmodule
